// File: rtl/usb_tx.sv
// Host-bound side of an FT245-style parallel USB FIFO link: buffers bytes, arbitrates
// for the shared data bus, generates wr/txe write timing and SI send-immediate pulses.
module usb_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int SETUP_CYC  = 2,
    parameter int WR_CYC     = 4,
    parameter int HOLD_CYC   = 2,
    parameter int RECOV_MAX  = 8,
    parameter int SI_CYC     = 4,
    parameter int IDLE_FLUSH = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          flush,
    output logic                          bus_req,
    input  logic                          bus_gnt,
    input  logic                          txe,
    output logic                          wr,
    output logic [7:0]                    d_out,
    output logic                          d_oe,
    output logic                          SI,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH) + 1 : 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [15:0]   SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0]   WR_LAST    = 16'(WR_CYC - 1);
    localparam logic [15:0]   HOLD_LAST  = 16'(HOLD_CYC - 1);
    localparam logic [15:0]   RECOV_LAST = 16'(RECOV_MAX - 1);
    localparam logic [15:0]   SI_LAST    = 16'(SI_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'((IDLE_FLUSH > 0) ? IDLE_FLUSH - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_RECOV  = 3'd5,
        ST_SI_P   = 3'd6
    } state_t;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic          tx_ready_r;
    logic          txe_meta_r;
    logic          txe_sync_r;
    state_t        state_r;
    logic [15:0]   cnt_r;
    logic          wr_r;
    logic          d_oe_r;
    logic [7:0]    d_out_r;
    logic          bus_req_r;
    logic          si_r;
    logic          pending_r;
    logic          written_r;
    logic [IW-1:0] idle_cnt_r;

    logic          push_s;
    logic          pop_s;
    logic          idle_run_s;
    logic          timeout_s;
    logic          si_entry_s;
    logic          recov_entry_s;
    logic [LW-1:0] count_next_s;

    // Handshake decode, FIFO next level and flush/timeout decisions.
    always_comb begin
        push_s        = tx_valid & tx_ready_r;
        pop_s         = (state_r == ST_ARB) & bus_gnt;
        idle_run_s    = (state_r == ST_IDLE) & (count_r == LEVEL_ZERO) & written_r;
        timeout_s     = (IDLE_FLUSH != 0) & idle_run_s & (idle_cnt_r == IDLE_LAST);
        // An expiring idle timer counts as a pending flush in the same cycle.
        si_entry_s    = (state_r == ST_IDLE) & (pending_r | timeout_s) & (count_r == LEVEL_ZERO);
        recov_entry_s = (state_r == ST_HOLD) & (cnt_r == HOLD_LAST);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + LEVEL_ONE;
            2'b01:   count_next_s = count_r - LEVEL_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; data words need no reset since pointers gate their use.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= LEVEL_ZERO;
            tx_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_next_s;
            tx_ready_r <= (count_next_s != LEVEL_FULL);
        end
    end

    // Two-flop synchronizer for txe; resets to "chip full" so nothing starts early.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txe_meta_r <= 1'b1;
            txe_sync_r <= 1'b1;
        end else begin
            txe_meta_r <= txe;
            txe_sync_r <= txe_meta_r;
        end
    end

    // Write/flush sequencer with registered bus and strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            wr_r      <= 1'b0;
            d_oe_r    <= 1'b0;
            d_out_r   <= 8'h00;
            bus_req_r <= 1'b0;
            si_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 16'd0;
                    if (si_entry_s) begin
                        state_r <= ST_SI_P;
                        si_r    <= 1'b0;
                    end else if ((count_r != LEVEL_ZERO) && !txe_sync_r) begin
                        state_r   <= ST_ARB;
                        bus_req_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARB: begin
                    if (bus_gnt) begin
                        state_r <= ST_SETUP;
                        d_out_r <= mem_r[rd_ptr_r];
                        d_oe_r  <= 1'b1;
                        cnt_r   <= 16'd0;
                    end else begin
                        state_r <= ST_ARB;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        state_r <= ST_STROBE;
                        wr_r    <= 1'b1;
                        cnt_r   <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_r == WR_LAST) begin
                        state_r <= ST_HOLD;
                        wr_r    <= 1'b0;
                        cnt_r   <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r   <= ST_RECOV;
                        d_oe_r    <= 1'b0;
                        bus_req_r <= 1'b0;
                        cnt_r     <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RECOV: begin
                    // Bounded wait: a chip that never pulses txe must not stall us.
                    if (txe_sync_r || (cnt_r == RECOV_LAST)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_SI_P: begin
                    if (cnt_r == SI_LAST) begin
                        state_r <= ST_IDLE;
                        si_r    <= 1'b1;
                        cnt_r   <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 16'd0;
                    wr_r      <= 1'b0;
                    d_oe_r    <= 1'b0;
                    bus_req_r <= 1'b0;
                    si_r      <= 1'b1;
                end
            endcase
        end
    end

    // Flush-pending flag, "written since last SI" flag and idle timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r  <= 1'b0;
            written_r  <= 1'b0;
            idle_cnt_r <= {IW{1'b0}};
        end else begin
            if (flush) begin
                pending_r <= 1'b1;
            end else if (si_entry_s) begin
                pending_r <= 1'b0;
            end
            if (si_entry_s) begin
                written_r <= 1'b0;
            end else if (recov_entry_s) begin
                written_r <= 1'b1;
            end
            if (push_s || si_entry_s) begin
                idle_cnt_r <= {IW{1'b0}};
            end else if (idle_run_s && (IDLE_FLUSH != 0)) begin
                idle_cnt_r <= idle_cnt_r + IW'(1);
            end
        end
    end

    assign tx_ready   = tx_ready_r;
    assign fifo_level = count_r;
    assign wr         = wr_r;
    assign d_oe       = d_oe_r;
    assign d_out      = d_out_r;
    assign bus_req    = bus_req_r;
    assign SI         = si_r;
    assign busy       = (state_r != ST_IDLE) | (count_r != LEVEL_ZERO);

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: a per-cycle vector table for the first write, then
// hand-written sequences for FIFO full, arbitration stall, flush ordering and reset.
module tb_usb_tx;

    logic       clk = 1'b0;
    logic       rst_n, tx_valid, tx_ready, flush, bus_req, bus_gnt, txe, wr, d_oe, SI, busy;
    logic [7:0] tx_data, d_out;
    logic [4:0] fifo_level;

    int total = 0;
    int bad   = 0;
    int cyc = 0, wr_falls = 0, si_pulses = 0, si_low = 0;
    int last_fall_cyc = 0, si_fall_cyc = 0, falls_at_si = 0;
    logic prev_wr = 1'b0, prev_si = 1'b1;
    logic [7:0] got_q [$];

    always #5 clk = ~clk;

    usb_tx #(.IDLE_FLUSH(32)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .flush(flush), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .txe(txe), .wr(wr), .d_out(d_out), .d_oe(d_oe), .SI(SI),
        .fifo_level(fifo_level), .busy(busy)
    );

    typedef struct {
        logic r, v; logic [7:0] d; logic t, g, f;
        logic e_wr, e_oe; logic [7:0] e_do; logic e_br, e_si, e_rdy; logic [4:0] e_lv; logic e_busy;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic r, v, input logic [7:0] d, input logic t, g, f,
                                input logic ew, eo, input logic [7:0] edo, input logic ebr, esi, erdy,
                                input logic [4:0] elv, input logic eb);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.t = t; x.g = g; x.f = f;
        x.e_wr = ew; x.e_oe = eo; x.e_do = edo; x.e_br = ebr; x.e_si = esi;
        x.e_rdy = erdy; x.e_lv = elv; x.e_busy = eb;
        return x;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge and edge events recorded.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_wr && !wr) begin
            got_q.push_back(d_out);
            wr_falls++;
            last_fall_cyc = cyc;
        end
        if (prev_si && !SI) begin
            si_pulses++;
            si_fall_cyc = cyc;
            falls_at_si = wr_falls;
        end
        if (!SI) si_low++;
        prev_wr = wr;
        prev_si = SI;
    endtask

    task automatic settle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            step();
            n++;
        end
        check("settle busy", busy, 0);
        repeat (50) step();
    endtask

    initial begin
        int n, idx, wr_seen, cyc_b;
        logic acc, flushed;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; flush = 1'b0; bus_gnt = 1'b1; txe = 1'b0;

        //             r  v  d      t  g  f   wr oe do     br si rdy lv     busy
        tbl[0]  = mk(0, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 1, 0, 5'd0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 1, 0, 5'd0, 0);
        tbl[2]  = mk(1, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 1, 1, 5'd0, 0);
        tbl[3]  = mk(1, 1, 8'hA5, 0, 1, 0,  0, 0, 8'h00, 0, 1, 1, 5'd1, 1);
        tbl[4]  = mk(1, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 1, 1, 1, 5'd1, 1);
        tbl[5]  = mk(1, 0, 8'h00, 0, 1, 0,  0, 1, 8'hA5, 1, 1, 1, 5'd0, 1);
        tbl[6]  = mk(1, 0, 8'h00, 0, 1, 0,  0, 1, 8'hA5, 1, 1, 1, 5'd0, 1);
        for (int i = 7; i <= 10; i++)
            tbl[i] = mk(1, 0, 8'h00, 0, 1, 0,  1, 1, 8'hA5, 1, 1, 1, 5'd0, 1);
        tbl[11] = mk(1, 0, 8'h00, 0, 1, 0,  0, 1, 8'hA5, 1, 1, 1, 5'd0, 1);
        tbl[12] = mk(1, 0, 8'h00, 0, 1, 0,  0, 1, 8'hA5, 1, 1, 1, 5'd0, 1);
        tbl[13] = mk(1, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 1, 1, 5'd0, 1);
        tbl[14] = mk(1, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 1, 1, 5'd0, 1);
        tbl[15] = mk(1, 1, 8'h3C, 0, 1, 0,  0, 0, 8'h00, 0, 1, 1, 5'd1, 1);
        for (int i = 16; i <= 21; i++)
            tbl[i] = mk(1, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 1, 1, 5'd1, 1);
        tbl[22] = mk(1, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 1, 1, 1, 5'd1, 1);
        tbl[23] = mk(1, 0, 8'h00, 0, 1, 0,  0, 1, 8'h3C, 1, 1, 1, 5'd0, 1);

        // Reset, first byte timing, RECOV timeout with txe stuck low, next byte start.
        for (int i = 0; i < 24; i++) begin
            rst_n = tbl[i].r; tx_valid = tbl[i].v; tx_data = tbl[i].d;
            txe = tbl[i].t; bus_gnt = tbl[i].g; flush = tbl[i].f;
            step();
            check($sformatf("r%0d wr", i), wr, tbl[i].e_wr);
            check($sformatf("r%0d d_oe", i), d_oe, tbl[i].e_oe);
            if (tbl[i].e_oe) check($sformatf("r%0d d_out", i), d_out, tbl[i].e_do);
            check($sformatf("r%0d bus_req", i), bus_req, tbl[i].e_br);
            check($sformatf("r%0d SI", i), SI, tbl[i].e_si);
            check($sformatf("r%0d tx_ready", i), tx_ready, tbl[i].e_rdy);
            check($sformatf("r%0d level", i), fifo_level, tbl[i].e_lv);
            check($sformatf("r%0d busy", i), busy, tbl[i].e_busy);
        end

        // Auto-flush: exactly one SI pulse 32 idle clocks after the last byte.
        si_pulses = 0; si_low = 0; n = 0;
        while (busy !== 1'b0 && n < 100) begin step(); n++; end
        check("3C done busy", busy, 0);
        cyc_b = cyc; n = 0;
        while (si_pulses == 0 && n < 100) begin step(); n++; end
        check("auto-flush delay", si_fall_cyc - cyc_b, 32);
        repeat (60) step();
        check("auto-flush pulses", si_pulses, 1);
        check("auto-flush SI width", si_low, 4);
        check("first bytes count", got_q.size(), 2);
        check("first byte", (got_q.size() > 0) ? got_q[0] : 8'hFF, 8'hA5);
        check("second byte", (got_q.size() > 1) ? got_q[1] : 8'hFF, 8'h3C);

        // USB full: FIFO fills to 16, then drains in order once txe drops.
        got_q.delete(); txe = 1'b1; repeat (3) step();
        idx = 0; wr_seen = 0;
        for (int k = 0; k < 25; k++) begin
            tx_valid = 1'b1; tx_data = 8'(idx); acc = tx_ready;
            step();
            if (acc) idx++;
            if (wr) wr_seen++;
        end
        tx_valid = 1'b0;
        repeat (20) begin step(); if (wr) wr_seen++; end
        check("full accepted", idx, 16);
        check("full tx_ready", tx_ready, 0);
        check("full level", fifo_level, 16);
        check("full wr toggles", wr_seen, 0);
        txe = 1'b0; n = 0;
        while (got_q.size() < 20 && n < 3000) begin
            tx_valid = (idx < 20); tx_data = 8'(idx); acc = tx_valid & tx_ready;
            step();
            if (acc) idx++;
            n++;
        end
        tx_valid = 1'b0;
        check("drain count", got_q.size(), 20);
        for (int i = 0; i < 20; i++)
            check($sformatf("drain byte %0d", i), (i < got_q.size()) ? got_q[i] : 8'hFF, i);
        settle();

        // Grant withheld for 50 clocks: bus_req held, no drive, no strobe.
        bus_gnt = 1'b0; tx_valid = 1'b1; tx_data = 8'h77;
        step();
        tx_valid = 1'b0;
        step();
        n = 0;
        repeat (50) begin
            step();
            if (bus_req !== 1'b1 || d_oe !== 1'b0 || wr !== 1'b0) n++;
        end
        check("no-grant violations", n, 0);
        bus_gnt = 1'b1;
        step();
        check("grant d_oe", d_oe, 1);
        check("grant d_out", d_out, 8'h77);
        check("grant wr", wr, 0);
        check("grant level", fifo_level, 0);
        settle();

        // Flush during the second of three bytes: SI only after the third byte's RECOV.
        got_q.delete(); wr_falls = 0; si_pulses = 0; si_low = 0; flushed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_data = 8'(8'h11 * (i + 1));
            step();
        end
        tx_valid = 1'b0;
        repeat (200) begin
            flush = (wr && wr_falls == 1 && !flushed);
            if (flush) flushed = 1'b1;
            step();
            flush = 1'b0;
        end
        check("flush applied", flushed, 1);
        check("flush pulses", si_pulses, 1);
        check("flush after bytes", falls_at_si, 3);
        check("flush gap", si_fall_cyc - last_fall_cyc, 11);
        check("flush SI width", si_low, 4);
        check("flush byte count", got_q.size(), 3);
        check("flush byte 3", (got_q.size() > 2) ? got_q[2] : 8'hFF, 8'h33);

        // Reset during STROBE drops everything on the same edge.
        tx_valid = 1'b1; tx_data = 8'hE1;
        step();
        tx_data = 8'hE2;
        step();
        tx_valid = 1'b0; n = 0;
        while (wr !== 1'b1 && n < 60) begin step(); n++; end
        check("strobe reached", wr, 1);
        rst_n = 1'b0;
        step();
        check("rst wr", wr, 0);
        check("rst d_oe", d_oe, 0);
        check("rst level", fifo_level, 0);
        check("rst SI", SI, 1);
        check("rst tx_ready", tx_ready, 0);
        check("rst busy", busy, 0);
        check("rst bus_req", bus_req, 0);
        rst_n = 1'b1;
        step();
        check("post-rst tx_ready", tx_ready, 1);
        repeat (5) step();
        check("post-rst idle wr", wr, 0);
        check("post-rst busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_tx.md
Name: usb_tx

Overview:
- Host-bound (write) side of the FT245-style parallel USB FIFO link; counterpart to the command receiver that reads `d` using `rxf`/`rd`.
- Buffers status/readback bytes from internal logic in a small FIFO.
- Writes each byte to the USB chip with `wr`/`txe` timing, after winning the shared `d` bus from the receiver.
- Drives `SI` (send-immediate) to flush partial USB packets to the host.

Parameters:
- FIFO_DEPTH, 16, internal byte FIFO depth; must be a power of 2, >= 2.
- SETUP_CYC, 2, clocks `d` is driven before `wr` rises (>= 1).
- WR_CYC, 4, clocks `wr` is held high (>= 1).
- HOLD_CYC, 2, clocks `d` stays driven after `wr` falls (>= 1).
- RECOV_MAX, 8, maximum clocks to wait for `txe` to go high after a write.
- SI_CYC, 4, clocks `SI` is held low per flush pulse.
- IDLE_FLUSH, 1024, idle clocks before auto-flush; 0 disables auto-flush.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- tx_data, in, 8, byte to send.
- tx_valid, in, 1, `tx_data` is valid.
- tx_ready, out, 1, FIFO can accept a byte; a transfer occurs when `tx_valid` & `tx_ready`.
- flush, in, 1, single-cycle request for an `SI` pulse.
- bus_req, out, 1, request ownership of `d`.
- bus_gnt, in, 1, `d` granted (receiver is idle).
- txe, in, 1, USB chip TXE#; low means there is space. Asynchronous.
- wr, out, 1, USB write strobe; chip latches data on the falling edge.
- d_out, out, 8, data to drive onto `d`.
- d_oe, out, 1, `d` output enable; the top level builds the tristate.
- SI, out, 1, send-immediate, active low.
- fifo_level, out, clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- busy, out, 1, high whenever the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low.
  - Reset values: wr=0, d_oe=0, d_out=0, SI=1, bus_req=0, tx_ready=0, fifo_level=0, busy=0. FIFO is emptied, FSM goes to IDLE, all counters clear.
  - tx_ready rises the first clock after rst_n goes high.
  - Reset mid-write drops wr and d_oe the same edge; the in-flight byte is discarded.
- txe synchronizer:
  - Two-flop synchronizer produces txe_s; all decisions use txe_s only.
- FIFO:
  - tx_ready = !full, registered from the count.
  - Push when tx_valid & tx_ready; pop on SETUP entry.
  - Push and pop in the same cycle leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push while full cannot occur, since tx_ready=0.
- FSM states:
  - IDLE:
    - If a flush is pending and the FIFO is empty, go to SI_P.
    - Else if the FIFO is non-empty and txe_s=0, assert bus_req and go to ARB.
  - ARB:
    - Hold bus_req=1 until bus_gnt=1.
    - Then pop a byte, set d_out=byte and d_oe=1, and go to SETUP.
  - SETUP: SETUP_CYC clocks, wr=0.
  - STROBE: WR_CYC clocks, wr=1.
  - HOLD: HOLD_CYC clocks, wr=0, d_oe=1.
  - RECOV:
    - d_oe=0 and bus_req=0 on entry.
    - Wait until txe_s=1 or RECOV_MAX clocks have elapsed, whichever comes first, then go to IDLE.
    - This prevents a stale txe_s=0 from starting a second write.
  - SI_P:
    - SI=0 for SI_CYC clocks, then SI=1 and go to IDLE.
    - Takes no bus ownership.
- Write timing:
  - Per byte, from SETUP entry to RECOV entry: SETUP_CYC+WR_CYC+HOLD_CYC clocks.
  - bus_req stays high from ARB through HOLD.
- Flush pending flag:
  - Set by flush=1 or by an idle timeout.
  - Cleared on SI_P entry.
  - A flush that arrives while the FIFO is non-empty waits until all bytes are written, so SI follows the last byte.
  - A flush that arrives during SI_P sets the flag again, giving one further pulse.
- Idle timeout:
  - The counter runs only when the FSM is in IDLE, the FIFO is empty, and at least one byte has been written since the last SI pulse.
  - On reaching IDLE_FLUSH it sets the pending flag.
  - It resets on any push or on SI_P entry.
- txe held high (USB full):
  - The FSM stays in IDLE and the FIFO fills.
  - tx_ready drops when the FIFO is full. No timeout; no bytes are dropped.
- bus_gnt behaviour:
  - bus_gnt dropping after grant is ignored until RECOV; the grant is only sampled in ARB.

Test Plan:
- Reset, then push 0xA5 with txe=0 and bus_gnt=1 → bus_req within 3 clocks (sync latency); d_out=0xA5 with d_oe=1; wr high for exactly 4 clocks after 2 setup clocks; d_oe drops 2 clocks after wr falls.
- txe=1 while pushing 20 bytes 0x00..0x13 → tx_ready=0 after 16 accepted, fifo_level=16, wr never toggles. Release txe → bytes 0x00..0x0F written in order, then 0x10..0x13 once re-offered.
- bus_gnt=0 held for 50 clocks with FIFO non-empty → bus_req=1, d_oe=0 and wr=0 throughout. Raise bus_gnt → SETUP starts the next clock.
- After a write, keep txe low (chip never pulses it) → RECOV exits after 8 clocks, and the next byte starts without a hang.
- Write 3 bytes, assert flush mid-second byte → SI low for 4 clocks only after the third byte's RECOV, SI=1 otherwise. With IDLE_FLUSH=32 and one byte written, SI pulses 32 idle clocks later exactly once.
- Drop rst_n during STROBE → next edge gives wr=0, d_oe=0, fifo_level=0, SI=1, tx_ready=0.
